if_id_stage: RTL and testbench
==============================

# if_id_stage

IF/ID pipeline register of the RV32I forwarding pipeline, combined with load-use hazard detection and redirect flush generation. It captures the fetched instruction and PC each cycle. It holds on a load-use hazard, injects a NOP on an EX-resolved redirect, and drives the ID/EX flush and the PC write enable. Two saturating counters record stall and flush cycles for performance analysis.

## Interface
- WB_SEL_LSU, 2'b00, wb_sel encoding meaning "write back load data"; identifies a load in EX.
- NOP_INST, 32'h00000013, instruction word loaded on reset and on flush (addi x0,x0,0).

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_IF_pc  in  32  PC of the fetched instruction.
- i_IF_pc_four  in  32  PC+4 of the fetched instruction.
- i_IF_inst  in  32  fetched instruction word.
- i_IF_mispred  in  1  fetch-side prediction tag, passed through.
- i_EX_inst  in  32  instruction currently in EX; rd = [11:7].
- i_EX_rd_wren  in  1  EX instruction writes rd.
- i_EX_wb_sel  in  2  EX write-back select.
- i_EX_redirect  in  1  branch/jump resolved in EX with wrong path fetched.
- i_ctr_clr  in  1  synchronous clear of both counters.
- o_ID_pc, o_ID_pc_four, o_ID_inst  out  32 each  registered IF/ID contents.
- o_ID_mispred  out  1  registered prediction tag.
- o_ID_insn_vld  out  1  ID holds a real instruction.
- o_pc_en  out  1  PC register write enable (combinational).
- o_ID_EX_flush  out  1  drives the ID/EX register flush (combinational).
- o_stall_cnt  out  32  load-use stall cycles, saturating.
- o_flush_cnt  out  32  redirect cycles, saturating.

## Operation
- Source fields: ID rs1 = o_ID_inst[19:15], rs2 = [24:20]; EX rd = i_EX_inst[11:7].
- uses_rs1: o_ID_inst[6:0] is not 0110111 (LUI), 0010111 (AUIPC), or 1101111 (JAL).
- uses_rs2: opcode is 0110011 (R), 0100011 (S), or 1100011 (B).
- load_use = state==RUN & o_ID_insn_vld & i_EX_rd_wren & i_EX_wb_sel==WB_SEL_LSU & rd!=0 & ((uses_rs1 & rd==rs1) | (uses_rs2 & rd==rs2)).
- FSM states are RUN and STALL. Reset enters RUN.
  - RUN -> STALL when load_use & !i_EX_redirect.
  - STALL -> RUN unconditionally after one cycle. Detection is masked in STALL, so a stall lasts at most one cycle per load.
- Priority: i_rst > i_EX_redirect > load_use > normal.
  - Redirect: IF/ID loads pc=0, pc_four=0, inst=NOP_INST, mispred=i_IF_mispred, insn_vld=0. o_ID_EX_flush=1, o_pc_en=1, state becomes RUN.
  - Load-use: IF/ID holds all fields. o_pc_en=0, o_ID_EX_flush=1.
  - Normal: IF/ID loads the i_IF_* fields with insn_vld=1. o_pc_en=1, o_ID_EX_flush=0.
- Counters: o_stall_cnt +1 on each load_use cycle (not masked by redirect), and o_flush_cnt +1 on each redirect cycle. Both saturate at 32'hFFFFFFFF.
- i_ctr_clr zeroes both counters. Clear wins over a same-cycle increment (result 0).

## Timing
- Reset values: o_ID_pc=0, o_ID_pc_four=0, o_ID_inst=NOP_INST, o_ID_mispred=0, o_ID_insn_vld=0, both counters=0, state=RUN.
- While i_rst=1: o_pc_en=0 and o_ID_EX_flush=1.
- IF -> ID latency is 1 cycle.
- o_pc_en and o_ID_EX_flush are same-cycle combinational functions of the current inputs and registered state. There is no combinational path from i_IF_* to any output.
- A load followed immediately by a dependent instruction costs exactly 1 bubble; the dependent instruction enters EX 2 cycles after the load.
- Redirect asserted during STALL: the redirect is applied and the FSM returns to RUN.
- Reset asserted mid-stall: the next cycle is RUN with the reset values.
- rd=x0 never stalls. An instruction with insn_vld=0 in ID never stalls.

## Test plan
- Reset, then feed pc=0x10/0x14/0x18 with distinct inst words -> each appears on o_ID_* one cycle later with insn_vld=1, o_pc_en=1, o_ID_EX_flush=0.
- EX holds lw x5 (rd_wren=1, wb_sel=00) while ID holds add x6,x5,x1 -> one cycle with o_pc_en=0, o_ID_EX_flush=1, ID held. The next cycle resumes, and o_stall_cnt=1.
- Same as the previous case but EX rd=x0, or ID is LUI x6 -> no stall; o_stall_cnt stays 0.
- i_EX_redirect pulsed for one cycle during load_use -> o_ID_inst=0x00000013, insn_vld=0, o_pc_en=1, o_flush_cnt=1, o_stall_cnt=1, state RUN.
- Force o_stall_cnt to 0xFFFFFFFE, then apply 3 stall events -> the counter holds at 0xFFFFFFFF. Then i_ctr_clr together with a stall event -> counter reads 0.
- i_rst asserted in STALL -> next cycle shows all reset values and state RUN; o_pc_en=0 while reset is high.

Source files
------------

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//
// IF/ID pipeline register of the RV32I forwarding pipeline, merged with
// load-use hazard detection and EX-redirect flush generation.
//
// Each cycle the fetched PC, PC+4, instruction and prediction tag are
// captured into the ID stage. A load in EX whose destination feeds the
// instruction in ID holds IF/ID and the PC for one cycle and bubbles ID/EX.
// A redirect resolved in EX replaces the ID contents with a NOP. Two
// saturating counters record stall and redirect cycles.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_IF_pc/_pc_four/_inst fetched PC, PC+4 and instruction word
//   i_IF_mispred           fetch-side prediction tag, passed through
//   i_EX_inst              instruction in EX (rd = [11:7])
//   i_EX_rd_wren           EX instruction writes rd
//   i_EX_wb_sel            EX write-back select (2'b00 = load data)
//   i_EX_redirect          EX-resolved redirect, wrong path fetched
//   i_ctr_clr              synchronous clear of both counters
//   o_ID_pc/_pc_four/_inst registered IF/ID contents
//   o_ID_mispred           registered prediction tag
//   o_ID_insn_vld          ID holds a real instruction
//   o_pc_en                PC write enable (combinational)
//   o_ID_EX_flush          ID/EX flush (combinational)
//   o_stall_cnt            load-use stall cycles, saturating
//   o_flush_cnt            redirect cycles, saturating
// -----------------------------------------------------------------------------
module if_id_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_IF_pc,
    input  logic [31:0] i_IF_pc_four,
    input  logic [31:0] i_IF_inst,
    input  logic        i_IF_mispred,
    input  logic [31:0] i_EX_inst,
    input  logic        i_EX_rd_wren,
    input  logic [1:0]  i_EX_wb_sel,
    input  logic        i_EX_redirect,
    input  logic        i_ctr_clr,
    output logic [31:0] o_ID_pc,
    output logic [31:0] o_ID_pc_four,
    output logic [31:0] o_ID_inst,
    output logic        o_ID_mispred,
    output logic        o_ID_insn_vld,
    output logic        o_pc_en,
    output logic        o_ID_EX_flush,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    localparam logic [1:0]  WB_SEL_LSU = 2'b00;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_four_q, pc_four_d;
    logic [31:0] inst_q, inst_d;
    logic        mispred_q, mispred_d;
    logic        vld_q, vld_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       uses_rs1, uses_rs2;
    logic       ex_is_load;
    logic       load_use;

    assign id_opcode = inst_q[6:0];
    assign id_rs1    = inst_q[19:15];
    assign id_rs2    = inst_q[24:20];
    assign ex_rd     = i_EX_inst[11:7];

    assign uses_rs1 = !(id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign uses_rs2 =   id_opcode inside {OP_REG, OP_STORE, OP_BRANCH};

    assign ex_is_load = i_EX_rd_wren && (i_EX_wb_sel == WB_SEL_LSU) && (ex_rd != 5'd0);

    // Detection is masked in STALL so one load can cost at most one bubble;
    // the held instruction then moves on while the load result is forwarded.
    assign load_use = (state_q == RUN) && vld_q && ex_is_load &&
                      ((uses_rs1 && (ex_rd == id_rs1)) ||
                       (uses_rs2 && (ex_rd == id_rs2)));

    // -------------------------------------------------------------------------
    // Next-state and control outputs
    // Priority: reset > redirect > load-use > normal.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        pc_four_d     = pc_four_q;
        inst_d        = inst_q;
        mispred_d     = mispred_q;
        vld_d         = vld_q;
        o_pc_en       = 1'b1;
        o_ID_EX_flush = 1'b0;

        if (i_rst) begin
            // Register contents are restored by the reset branch of the
            // state register; only the control outputs matter here.
            o_pc_en       = 1'b0;
            o_ID_EX_flush = 1'b1;
        end else if (i_EX_redirect) begin
            pc_d          = 32'd0;
            pc_four_d     = 32'd0;
            inst_d        = NOP_INST;
            mispred_d     = i_IF_mispred;
            vld_d         = 1'b0;
            state_d       = RUN;
            o_pc_en       = 1'b1;
            o_ID_EX_flush = 1'b1;
        end else if (load_use) begin
            state_d       = STALL;
            o_pc_en       = 1'b0;
            o_ID_EX_flush = 1'b1;
        end else begin
            pc_d          = i_IF_pc;
            pc_four_d     = i_IF_pc_four;
            inst_d        = i_IF_inst;
            mispred_d     = i_IF_mispred;
            vld_d         = 1'b1;
            state_d       = RUN;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters; clear beats a same-cycle increment.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (i_ctr_clr) begin
            stall_cnt_d = 32'd0;
            flush_cnt_d = 32'd0;
        end else begin
            if (load_use && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (i_EX_redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its inputs.
        if (i_rst) begin
            state_q     <= RUN;
            pc_q        <= 32'd0;
            pc_four_q   <= 32'd0;
            inst_q      <= NOP_INST;
            mispred_q   <= 1'b0;
            vld_q       <= 1'b0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_four_q   <= pc_four_d;
            inst_q      <= inst_d;
            mispred_q   <= mispred_d;
            vld_q       <= vld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_ID_pc       = pc_q;
    assign o_ID_pc_four  = pc_four_q;
    assign o_ID_inst     = inst_q;
    assign o_ID_mispred  = mispred_q;
    assign o_ID_insn_vld = vld_q;
    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
//
// Scoreboard bench for if_id_stage. The driver applies one cycle of stimulus
// on each falling edge, evaluates a behavioural pipeline model and pushes the
// expected control outputs and post-edge register contents into a queue. The
// monitor pops one entry per driven cycle, compares the combinational outputs
// shortly after the falling edge and the registered outputs just after the
// following rising edge.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADD_X6   = 32'h0012_8333; // add x6,x5,x1
    localparam logic [31:0] LUI_X6   = 32'h0000_6337; // lui x6,6
    localparam logic [31:0] LW_X5    = 32'h0000_A283; // lw  x5,0(x1)
    localparam logic [31:0] LW_X0    = 32'h0000_A003; // lw  x0,0(x1)
    localparam logic [31:0] SAT      = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc, if_pc_four, if_inst, ex_inst;
    logic        if_mispred, ex_rd_wren, ex_redirect, ctr_clr;
    logic [1:0]  ex_wb_sel;
    logic [31:0] id_pc, id_pc_four, id_inst, stall_cnt, flush_cnt;
    logic        id_mispred, id_insn_vld, pc_en, id_ex_flush;

    always #5 clk = ~clk;

    if_id_stage dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_IF_pc       (if_pc),
        .i_IF_pc_four  (if_pc_four),
        .i_IF_inst     (if_inst),
        .i_IF_mispred  (if_mispred),
        .i_EX_inst     (ex_inst),
        .i_EX_rd_wren  (ex_rd_wren),
        .i_EX_wb_sel   (ex_wb_sel),
        .i_EX_redirect (ex_redirect),
        .i_ctr_clr     (ctr_clr),
        .o_ID_pc       (id_pc),
        .o_ID_pc_four  (id_pc_four),
        .o_ID_inst     (id_inst),
        .o_ID_mispred  (id_mispred),
        .o_ID_insn_vld (id_insn_vld),
        .o_pc_en       (pc_en),
        .o_ID_EX_flush (id_ex_flush),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        mis;
        logic [31:0] ex_inst;
        logic        wren;
        logic [1:0]  wbsel;
        logic        redirect;
        logic        clr;
    } stim_t;

    typedef struct {
        logic        pc_en;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        mis;
        logic        vld;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model of the pipeline register contents
    logic [31:0] m_pc, m_pc4, m_inst, m_scnt, m_fcnt;
    logic        m_mis, m_vld;
    bit          m_bubbled;   // previous cycle was a load-use bubble

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        logic [32:0] t;
        t = {1'b0, v} + 33'd1;
        return t[32] ? SAT : t[31:0];
    endfunction

    // Does the instruction in ID need the value the load in EX is producing?
    function automatic bit needs_load(input logic [31:0] id, input logic [31:0] ex);
        logic [6:0] op;
        logic [4:0] rd;
        bit         reads_rs1, reads_rs2;
        op        = id[6:0];
        rd        = ex[11:7];
        reads_rs1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        reads_rs2 =   op inside {7'b0110011, 7'b0100011, 7'b1100011};
        if (rd == 5'd0) return 1'b0;
        return (reads_rs1 && id[19:15] == rd) || (reads_rs2 && id[24:20] == rd);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.pc = 32'd0; s.pc4 = 32'd4; s.inst = NOP; s.mis = 1'b0;
        s.ex_inst = NOP; s.wren = 1'b0; s.wbsel = 2'b01; s.redirect = 1'b0; s.clr = 1'b0;
        return s;
    endfunction

    // One clock cycle of stimulus plus the model's prediction for it.
    task automatic step(input stim_t s, input bit preload_stall = 1'b0);
        exp_t e;
        bit   hazard;
        @(negedge clk);
        rst         = s.rst;
        if_pc       = s.pc;
        if_pc_four  = s.pc4;
        if_inst     = s.inst;
        if_mispred  = s.mis;
        ex_inst     = s.ex_inst;
        ex_rd_wren  = s.wren;
        ex_wb_sel   = s.wbsel;
        ex_redirect = s.redirect;
        ctr_clr     = s.clr;
        if (preload_stall) begin
            force dut.stall_cnt_q = 32'hFFFF_FFFE;
            #1;
            release dut.stall_cnt_q;
            m_scnt = 32'hFFFF_FFFE;
        end

        hazard = !m_bubbled && m_vld && s.wren && (s.wbsel == 2'b00) &&
                 needs_load(m_inst, s.ex_inst);

        if (s.rst) begin
            e.pc_en = 1'b0;
            e.flush = 1'b1;
            m_pc = 32'd0; m_pc4 = 32'd0; m_inst = NOP; m_mis = 1'b0; m_vld = 1'b0;
            m_scnt = 32'd0; m_fcnt = 32'd0; m_bubbled = 1'b0;
        end else begin
            e.pc_en = s.redirect || !hazard;
            e.flush = s.redirect || hazard;
            m_scnt  = s.clr ? 32'd0 : (hazard     ? sat_inc(m_scnt) : m_scnt);
            m_fcnt  = s.clr ? 32'd0 : (s.redirect ? sat_inc(m_fcnt) : m_fcnt);
            if (s.redirect) begin
                m_pc = 32'd0; m_pc4 = 32'd0; m_inst = NOP; m_mis = s.mis; m_vld = 1'b0;
                m_bubbled = 1'b0;
            end else if (hazard) begin
                m_bubbled = 1'b1;
            end else begin
                m_pc = s.pc; m_pc4 = s.pc4; m_inst = s.inst; m_mis = s.mis; m_vld = 1'b1;
                m_bubbled = 1'b0;
            end
        end
        e.pc = m_pc; e.pc4 = m_pc4; e.inst = m_inst; e.mis = m_mis; e.vld = m_vld;
        e.scnt = m_scnt; e.fcnt = m_fcnt;
        exp_q.push_back(e);
    endtask

    // Monitor: compares whenever a driven cycle is pending in the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc_en", {31'd0, pc_en},       {31'd0, e.pc_en});
                check("flush", {31'd0, id_ex_flush}, {31'd0, e.flush});
                @(posedge clk);
                #1;
                check("id_pc",      id_pc,      e.pc);
                check("id_pc_four", id_pc_four, e.pc4);
                check("id_inst",    id_inst,    e.inst);
                check("id_mispred", {31'd0, id_mispred},  {31'd0, e.mis});
                check("id_vld",     {31'd0, id_insn_vld}, {31'd0, e.vld});
                check("stall_cnt",  stall_cnt,  e.scnt);
                check("flush_cnt",  flush_cnt,  e.fcnt);
            end
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [9];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 8)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        stim_t s;
        int    wait_cycles;
        rst = 1'b1; if_pc = '0; if_pc_four = '0; if_inst = NOP; if_mispred = 1'b0;
        ex_inst = NOP; ex_rd_wren = 1'b0; ex_wb_sel = 2'b01; ex_redirect = 1'b0; ctr_clr = 1'b0;
        m_pc = '0; m_pc4 = '0; m_inst = NOP; m_mis = 1'b0; m_vld = 1'b0;
        m_scnt = '0; m_fcnt = '0; m_bubbled = 1'b0;

        // Reset
        s = idle(); s.rst = 1'b1;
        step(s); step(s);

        // Straight-line fetch
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.pc = 32'h10 + 32'(4 * i); s.pc4 = s.pc + 32'd4;
            s.inst = 32'h0000_1093 + 32'(i << 20); s.mis = i[0];
            step(s);
        end

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID -> one bubble
        s = idle(); s.pc = 32'h20; s.pc4 = 32'h24; s.inst = ADD_X6; step(s);
        s = idle(); s.pc = 32'h24; s.pc4 = 32'h28; s.ex_inst = LW_X5; s.wren = 1'b1; s.wbsel = 2'b00; step(s);
        s = idle(); s.pc = 32'h24; s.pc4 = 32'h28; step(s);
        s = idle(); s.pc = 32'h28; s.pc4 = 32'h2c; step(s);

        // No stall: rd=x0, and ID is LUI
        s = idle(); s.rst = 1'b1; step(s);
        s = idle(); s.pc = 32'h30; s.pc4 = 32'h34; s.inst = ADD_X6; step(s);
        s = idle(); s.pc = 32'h34; s.pc4 = 32'h38; s.inst = LUI_X6;
        s.ex_inst = LW_X0; s.wren = 1'b1; s.wbsel = 2'b00; step(s);
        s = idle(); s.pc = 32'h38; s.pc4 = 32'h3c; s.ex_inst = LW_X5; s.wren = 1'b1; s.wbsel = 2'b00; step(s);

        // Redirect during load-use
        s = idle(); s.pc = 32'h40; s.pc4 = 32'h44; s.inst = ADD_X6; step(s);
        s = idle(); s.pc = 32'h44; s.mis = 1'b1; s.ex_inst = LW_X5; s.wren = 1'b1; s.wbsel = 2'b00;
        s.redirect = 1'b1; step(s);
        s = idle(); s.pc = 32'h80; s.pc4 = 32'h84; step(s);

        // Saturation from 0xFFFFFFFE with three stall events, then clear+stall
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.pc = 32'h50; s.pc4 = 32'h54; s.inst = ADD_X6; step(s, i == 0);
            s = idle(); s.ex_inst = LW_X5; s.wren = 1'b1; s.wbsel = 2'b00; step(s);
        end
        s = idle(); s.inst = ADD_X6; step(s);
        s = idle(); s.ex_inst = LW_X5; s.wren = 1'b1; s.wbsel = 2'b00; s.clr = 1'b1; step(s);

        // Reset while in STALL, then a dependent pair must stall again
        s = idle(); s.inst = ADD_X6; step(s);
        s = idle(); s.ex_inst = LW_X5; s.wren = 1'b1; s.wbsel = 2'b00; step(s);
        s = idle(); s.rst = 1'b1; s.ex_inst = LW_X5; s.wren = 1'b1; s.wbsel = 2'b00; step(s);
        s = idle(); s.inst = ADD_X6; step(s);
        s = idle(); s.ex_inst = LW_X5; s.wren = 1'b1; s.wbsel = 2'b00; step(s);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            s.rst      = ($urandom_range(0, 99) == 0);
            s.pc       = $urandom;
            s.pc4      = s.pc + 32'd4;
            s.inst     = rand_inst();
            s.mis      = 1'($urandom);
            s.ex_inst  = rand_inst();
            s.wren     = ($urandom_range(0, 9) < 7);
            s.wbsel    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            s.redirect = ($urandom_range(0, 9) == 0);
            s.clr      = ($urandom_range(0, 49) == 0);
            step(s);
        end

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
